// File: rtl/register_fetch.sv
// register_fetch -- operand-fetch stage.
//
// During the sequencer's register-fetch step, reads the frame base pointer
// (ci->u.l.base), then the value and tag words of RK(B) and RK(C) over the
// shared Avalon master. The fetched operands and the base pointer are held
// for the execute/writeback stage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_*             Avalon master; all outputs are zero while not reading,
//                     so the top level can OR them with other bus users
//   fetch_regs        level request, held until done
//   ci, k_base        CallInfo pointer, constant-array pointer
//   B, C              decoded operand fields (bit 8 = constant flag)
//   need_b, need_c    which operands to fetch
//   base              captured frame base
//   val_b/tag_b       RK(B) value word / tag
//   val_c/tag_c       RK(C) value word / tag
//   done              one-cycle completion pulse (registered)
module register_fetch #(
    parameter int CI_BASE_OFFSET = 16,
    parameter int TV_SIZE_LOG2   = 3,
    parameter int TAG_OFFSET     = 4,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [31:0]          mem_address,
    input  logic [31:0]          mem_readdata,
    output logic [31:0]          mem_writedata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_waitrequest,
    input  logic                 fetch_regs,
    input  logic [31:0]          ci,
    input  logic [31:0]          k_base,
    input  logic [8:0]           B,
    input  logic [8:0]           C,
    input  logic                 need_b,
    input  logic                 need_c,
    output logic [31:0]          base,
    output logic [31:0]          val_b,
    output logic [TAG_WIDTH-1:0] tag_b,
    output logic [31:0]          val_c,
    output logic [TAG_WIDTH-1:0] tag_c,
    output logic                 done
);

    localparam logic [31:0] CI_OFF  = 32'(CI_BASE_OFFSET);
    localparam logic [31:0] TAG_OFF = 32'(TAG_OFFSET);

    typedef enum logic [2:0] {
        IDLE, RD_BASE, RD_BV, RD_BT, RD_CV, RD_CT, FIN
    } state_t;

    state_t state;

    logic [31:0] b_addr;
    logic [31:0] c_addr;

    // Operand addresses use the base register, which by RD_BV/RD_CV already
    // holds the value captured in RD_BASE of this same fetch.
    always_comb begin
        b_addr = (B[8] ? k_base : base) + ({24'd0, B[7:0]} << TV_SIZE_LOG2);
        c_addr = (C[8] ? k_base : base) + ({24'd0, C[7:0]} << TV_SIZE_LOG2);
    end

    // Bus outputs are gated by fetch_regs so an abort drops mem_read in the
    // same cycle rather than one cycle later.
    always_comb begin
        mem_read    = 1'b0;
        mem_address = '0;
        if (fetch_regs) begin
            case (state)
                RD_BASE: begin mem_read = 1'b1; mem_address = ci + CI_OFF;      end
                RD_BV:   begin mem_read = 1'b1; mem_address = b_addr;           end
                RD_BT:   begin mem_read = 1'b1; mem_address = b_addr + TAG_OFF; end
                RD_CV:   begin mem_read = 1'b1; mem_address = c_addr;           end
                RD_CT:   begin mem_read = 1'b1; mem_address = c_addr + TAG_OFF; end
                default: ;
            endcase
        end
    end

    assign mem_writedata = '0;
    assign mem_write     = 1'b0;

    // done is raised on the edge that enters FIN, so it is high exactly
    // while the FSM sits in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            val_b <= '0;
            tag_b <= '0;
            val_c <= '0;
            tag_c <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && !fetch_regs) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (fetch_regs) state <= RD_BASE;
                    RD_BASE: if (!mem_waitrequest) begin
                        base <= mem_readdata;
                        if (need_b)      state <= RD_BV;
                        else if (need_c) state <= RD_CV;
                        else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                    RD_BV: if (!mem_waitrequest) begin
                        val_b <= mem_readdata;
                        state <= RD_BT;
                    end
                    RD_BT: if (!mem_waitrequest) begin
                        tag_b <= mem_readdata[TAG_WIDTH-1:0];
                        if (need_c) state <= RD_CV;
                        else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                    RD_CV: if (!mem_waitrequest) begin
                        val_c <= mem_readdata;
                        state <= RD_CT;
                    end
                    RD_CT: if (!mem_waitrequest) begin
                        tag_c <= mem_readdata[TAG_WIDTH-1:0];
                        state <= FIN;
                        done  <= 1'b1;
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_register_fetch.sv
// Self-checking bench for register_fetch: directed test-plan steps followed
// by randomized fetches, all checked against a transaction-level model.
module tb_register_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_readdata;
    logic [31:0] mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_waitrequest;
    logic        fetch_regs;
    logic [31:0] ci;
    logic [31:0] k_base;
    logic [8:0]  B;
    logic [8:0]  C;
    logic        need_b;
    logic        need_c;
    logic [31:0] base;
    logic [31:0] val_b;
    logic [7:0]  tag_b;
    logic [31:0] val_c;
    logic [7:0]  tag_c;
    logic        done;

    always #5 clk = ~clk;

    register_fetch dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_readdata(mem_readdata),
        .mem_writedata(mem_writedata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
        .fetch_regs(fetch_regs), .ci(ci), .k_base(k_base),
        .B(B), .C(C), .need_b(need_b), .need_c(need_c),
        .base(base), .val_b(val_b), .tag_b(tag_b),
        .val_c(val_c), .tag_c(tag_c), .done(done)
    );

    // ---------------- memory / slave model ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign mem_readdata = memval(mem_address);

    int wait_n = 0;
    int stall_cnt = 0;
    logic will_stall = 1'b0;
    assign mem_waitrequest = mem_read && (stall_cnt < wait_n);

    always @(posedge clk) stall_cnt <= will_stall ? stall_cnt + 1 : 0;

    // Bus monitor, sampled mid-cycle when everything is settled.
    logic [31:0] obs_q[$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = '0;
    int          unstable = 0;
    int          bus_bad = 0;

    always @(negedge clk) begin
        will_stall <= mem_read && mem_waitrequest;
        if (mem_read && !mem_waitrequest && !rst) obs_q.push_back(mem_address);
        if (stall_prev && mem_read && mem_address !== stall_addr) unstable <= unstable + 1;
        stall_prev <= mem_read && mem_waitrequest;
        stall_addr <= mem_address;
        if (mem_write !== 1'b0 || mem_writedata !== 32'd0 ||
            (!mem_read && mem_address !== 32'd0)) bus_bad <= bus_bad + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: what the operand registers should hold.
    logic [31:0] e_base = '0, e_vb = '0, e_vc = '0;
    logic [7:0]  e_tb = '0, e_tc = '0;

    task automatic chk_regs(input string tag);
        chk({tag, ".base"},  base,  e_base);
        chk({tag, ".val_b"}, val_b, e_vb);
        chk({tag, ".tag_b"}, {24'd0, tag_b}, {24'd0, e_tb});
        chk({tag, ".val_c"}, val_c, e_vc);
        chk({tag, ".tag_c"}, {24'd0, tag_c}, {24'd0, e_tc});
    endtask

    // One complete fetch: model the expected transactions, drive, and check.
    task automatic do_fetch(input string tag, input logic [31:0] ci_i, input logic [31:0] kb_i,
                            input logic [31:0] base_i, input logic [8:0] b_i, input logic [8:0] c_i,
                            input logic nb, input logic nc, input int w, output int lat);
        logic [31:0] exp_a[$];
        logic [31:0] a, t;
        int n, exp_lat;
        mem[ci_i + 32'd16] = base_i;
        exp_a.push_back(ci_i + 32'd16);
        e_base = base_i;
        if (nb) begin
            a = (b_i[8] ? kb_i : base_i) + 32'(b_i[7:0]) * 8;
            exp_a.push_back(a);
            exp_a.push_back(a + 4);
            e_vb = memval(a);
            t = memval(a + 4);
            e_tb = t[7:0];
        end
        if (nc) begin
            a = (c_i[8] ? kb_i : base_i) + 32'(c_i[7:0]) * 8;
            exp_a.push_back(a);
            exp_a.push_back(a + 4);
            e_vc = memval(a);
            t = memval(a + 4);
            e_tc = t[7:0];
        end
        exp_lat = exp_a.size() * (w + 1) + 1;

        ci = ci_i; k_base = kb_i; B = b_i; C = c_i; need_b = nb; need_c = nc;
        wait_n = w;
        obs_q.delete();
        fetch_regs = 1'b1;
        lat = -1;
        for (n = 1; n <= 200; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk_regs(tag);
        chk({tag, ".nreads"}, 32'(obs_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < obs_q.size(); i++)
            chk({tag, ".addr"}, obs_q[i], exp_a[i]);
        fetch_regs = 1'b0;
        tick();
        chk({tag, ".done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1; fetch_regs = 1'b0; ci = '0; k_base = '0;
        B = '0; C = '0; need_b = 1'b0; need_c = 1'b0;

        // Reset then idle
        tick(); tick();
        chk("rst.done", {31'd0, done}, 32'd0);
        chk_regs("rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.mem_read", {31'd0, mem_read}, 32'd0);
            chk("idle.mem_address", mem_address, 32'd0);
        end

        // Full fetch, zero wait
        do_fetch("full", 32'h1000, 32'h3000, 32'h2000, 9'h003, 9'h005, 1'b1, 1'b1, 0, lat);
        chk("full.lat6", 32'(lat), 32'd6);
        if (obs_q.size() == 5) begin
            chk("full.a1", obs_q[1], 32'h2018);
            chk("full.a4", obs_q[4], 32'h202C);
        end

        // Constant operand, need_b = 0
        do_fetch("const", 32'h1000, 32'h3000, 32'h2000, 9'h003, 9'h102, 1'b0, 1'b1, 0, lat);
        if (obs_q.size() == 3) chk("const.a1", obs_q[1], 32'h3010);

        // Wait states
        do_fetch("wait", 32'h1000, 32'h3000, 32'h2400, 9'h011, 9'h0FF, 1'b1, 1'b1, 3, lat);
        chk("wait.lat21", 32'(lat), 32'd21);

        // Neither operand
        do_fetch("none", 32'h4000, 32'h3000, 32'h5000, 9'h001, 9'h002, 1'b0, 1'b0, 0, lat);
        chk("none.lat2", 32'(lat), 32'd2);

        // Abort in RD_BT: base and val_b captured, tag_b and C side kept.
        mem[32'h1010] = 32'h6000;
        ci = 32'h1000; B = 9'h004; C = 9'h006; need_b = 1'b1; need_c = 1'b1;
        wait_n = 0;
        fetch_regs = 1'b1;
        tick(); tick(); tick();
        e_base = 32'h6000;
        e_vb = memval(32'h6020);
        fetch_regs = 1'b0;
        #1;
        chk("abort.mem_read_now", {31'd0, mem_read}, 32'd0);
        chk("abort.addr_now", mem_address, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort.no_done", {31'd0, done}, 32'd0);
            chk("abort.mem_read", {31'd0, mem_read}, 32'd0);
        end
        chk_regs("abort");

        // Reset in RD_CV
        fetch_regs = 1'b1;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        e_base = '0; e_vb = '0; e_tb = '0; e_vc = '0; e_tc = '0;
        chk("rstmid.done", {31'd0, done}, 32'd0);
        chk("rstmid.mem_read", {31'd0, mem_read}, 32'd0);
        chk_regs("rstmid");
        rst = 1'b0; fetch_regs = 1'b0;
        tick();

        // Randomized fetches
        for (int it = 0; it < 20; it++) begin
            do_fetch("rand", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFF8,
                     $urandom & 32'hFFFF_FFF8, 9'($urandom), 9'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(0, 2), lat);
        end

        chk("bus.addr_stable", 32'(unstable), 32'd0);
        chk("bus.idle_zero", 32'(bus_bad), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/register_fetch.md
Name: register_fetch

Overview:
- Operand-fetch stage; runs after the instruction register/decoder during the sequencer's register-fetch step.
- Reads the frame base pointer `ci->u.l.base`, then the operand TValues RK(B) and RK(C) (value word and tag word each) over the shared Avalon master.
- Presents the operands and the base pointer to the execute/writeback stage.
- Memory outputs are all-zero when not requesting, so the top level can OR-combine them with the other memory users.

Parameters:
- CI_BASE_OFFSET, 16: byte offset of `u.l.base` inside CallInfo.
- TV_SIZE_LOG2, 3: log2 of TValue size in bytes (8).
- TAG_OFFSET, 4: byte offset of the tag word within a TValue.
- TAG_WIDTH, 8: low bits of the tag word that are captured.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mem_address  out  32  Avalon byte address; 0 when idle.
- mem_readdata  in  32  Avalon read data.
- mem_writedata  out  32  always 0.
- mem_read  out  1  read request.
- mem_write  out  1  always 0.
- mem_waitrequest  in  1  Avalon stall.
- fetch_regs  in  1  level request from the sequencer; held until done.
- ci  in  32  CallInfo pointer.
- k_base  in  32  constant-array pointer.
- B  in  9  decoded B field; bit 8 = constant flag.
- C  in  9  decoded C field; bit 8 = constant flag.
- need_b  in  1  fetch RK(B).
- need_c  in  1  fetch RK(C).
- base  out  32  captured frame base.
- val_b  out  32  RK(B) value word.
- tag_b  out  TAG_WIDTH  RK(B) tag.
- val_c  out  32  RK(C) value word.
- tag_c  out  TAG_WIDTH  RK(C) tag.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous): state = IDLE; base, val_b, val_c, tag_b, tag_c, done all 0.
- States: IDLE, RD_BASE, RD_BV, RD_BT, RD_CV, RD_CT, FIN.
- IDLE → RD_BASE when fetch_regs = 1.
- Read state rules:
  - mem_read = 1 and mem_address is driven combinationally for the whole state.
  - When mem_waitrequest = 0 at a clock edge, mem_readdata is captured and the state advances; otherwise the state holds.
  - Each read takes at least 1 cycle.
- Read addresses (all 32-bit modulo-2^32 arithmetic, no overflow detection):
  - RD_BASE: ci + CI_BASE_OFFSET.
  - RD_BV: (B[8] ? k_base : base) + (B[7:0] << TV_SIZE_LOG2).
  - RD_BT: the RD_BV address + TAG_OFFSET.
  - RD_CV / RD_CT: same as RD_BV / RD_BT, using C.
  - RD_BV uses the freshly captured base register, never the stale one.
- Transitions:
  - From RD_BASE: to RD_BV if need_b, else to RD_CV if need_c, else to FIN.
  - RD_BV → RD_BT.
  - From RD_BT: to RD_CV if need_c, else to FIN.
  - RD_CV → RD_CT → FIN.
- Captured tag = mem_readdata[TAG_WIDTH-1:0].
- FIN:
  - done = 1 for exactly one cycle; mem_read = 0.
  - Next state is IDLE.
  - done is registered: it is high during the cycle after the last captured read.
- Operand registers hold their values until overwritten by a later fetch; skipped operands keep their old values.
- Minimum latency with zero wait states: need_b = need_c = 1 gives 5 read cycles + FIN, so done rises 6 cycles after fetch_regs.
- B, C, need_b, need_c, ci and k_base must stay stable while fetch_regs is high; they are sampled combinationally each state.
- Abort: fetch_regs dropping to 0 in any non-IDLE state forces IDLE on the next edge. No done pulse is produced and partially captured registers keep what was captured. mem_read goes low in the same cycle, because the outputs are gated by fetch_regs.
- rst asserted mid-read returns to IDLE with all outputs cleared; an outstanding Avalon read is simply abandoned.
- Back-to-back requests: fetch_regs still high in the cycle after FIN restarts at RD_BASE. The sequencer lowers fetch_regs on done to avoid this.
- Never writes memory.

Test Plan:
- Reset then idle:
  - Stimulus: rst = 1 for 2 cycles, then fetch_regs = 0.
  - Required: every output is 0, and mem_read and mem_address stay 0.
- Full fetch, zero wait:
  - Stimulus: ci = 0x1000, mem[0x1010] = 0x2000, B = 0x003, C = 0x005, need_b = need_c = 1.
  - Required: read addresses are 0x1010, 0x2018, 0x201C, 0x2028, 0x202C in that order; done pulses 6 cycles after request; base = 0x2000; values and tags match memory.
- Constant operand:
  - Stimulus: C = 0x102, k_base = 0x3000, need_b = 0.
  - Required: reads go to 0x1010, 0x3010, 0x3014; val_b and tag_b are unchanged from before.
- Wait states:
  - Stimulus: waitrequest held high for 3 cycles on each read.
  - Required: address stays stable during each stall; the correct data is captured; done arrives 6 + 5×3 = 21 cycles after request.
- Abort and reset mid-operation:
  - Abort stimulus: drop fetch_regs in RD_BT. Required: IDLE next cycle, no done pulse, mem_read = 0.
  - Reset stimulus: assert rst in RD_CV. Required: all outputs 0 on the next edge.
- need_b = need_c = 0:
  - Required: only the base read occurs, and done pulses 2 cycles after request.
